// File: rtl/result_pkg.sv
// Shared types and constants for the result RAM drain logic.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package result_pkg;

  // Default geometry: 128 result elements, 24-bit data/checksum.
  localparam int DEF_ADDR_WIDTH   = 7;
  localparam int DEF_RESULT_WIDTH = 24;

  // All-ones address; sliced to the actual address width by the user.
  localparam logic [31:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    SEND_A,
    SEND_B,
    DONE
  } reader_state_t;

endpackage

// File: rtl/result_reader.sv
// Drains the dual-port result RAM (port A even, port B odd addresses) onto a
// valid/ready stream while accumulating a modulo checksum against expected_sum.
// Latency: first out_valid two cycles after the accepted start; 4 cycles per
// address pair with out_ready high; done pulses the cycle after the last
// transfer. Backpressure: out_ready low holds the current element stable in
// SEND_A/SEND_B; RAM fetches are only issued once both elements of the previous
// pair have been accepted.
//
// Ports:
//   clock, reset         : single clock, asynchronous active-high reset
//   start, expected_sum  : drain request (IDLE only) and reference sum
//   addrA/addrB, qA/qB   : RAM read addresses and data (1-cycle read latency)
//   out_data/valid/ready/last : element stream
//   busy, done           : activity flag and one-cycle completion pulse
//   checksum, sum_match  : running sum and final comparison result
module result_reader
  import result_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int RESULT_WIDTH = DEF_RESULT_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [RESULT_WIDTH-1:0] expected_sum,
  output logic [ADDR_WIDTH-1:0]   addrA,
  output logic [ADDR_WIDTH-1:0]   addrB,
  input  logic [RESULT_WIDTH-1:0] qA,
  input  logic [RESULT_WIDTH-1:0] qB,
  output logic [RESULT_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic [RESULT_WIDTH-1:0] checksum,
  output logic                    sum_match
);

  // Pair index: addrA = {pair, 0}, addrB = {pair, 1}, so the two ports can
  // never fall out of step.
  localparam int PW = ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_B = LAST_ADDR[ADDR_WIDTH-1:0];

  reader_state_t           state_q, state_d;
  logic [PW-1:0]           pair_q, pair_d;
  logic [RESULT_WIDTH-1:0] hold_a_q, hold_a_d;
  logic [RESULT_WIDTH-1:0] hold_b_q, hold_b_d;
  logic [RESULT_WIDTH-1:0] csum_q, csum_d;
  logic [RESULT_WIDTH-1:0] exp_q, exp_d;
  logic                    match_q, match_d;

  logic                    is_last;

  assign addrA     = {pair_q, 1'b0};
  assign addrB     = {pair_q, 1'b1};
  assign is_last   = (addrB == LAST_B);
  assign busy      = (state_q != IDLE);
  assign checksum  = csum_q;
  assign sum_match = match_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pair_q   <= '0;
      hold_a_q <= '0;
      hold_b_q <= '0;
      csum_q   <= '0;
      exp_q    <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pair_q   <= pair_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      csum_q   <= csum_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pair_d    = pair_q;
    hold_a_d  = hold_a_q;
    hold_b_d  = hold_b_q;
    csum_d    = csum_q;
    exp_d     = exp_q;
    match_d   = match_q;
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pair_d  = '0;
          csum_d  = '0;
          match_d = 1'b0;
          exp_d   = expected_sum;
        end
      end

      // Addresses are held here so the RAM samples them on this edge.
      FETCH: begin
        state_d = CAPTURE;
      end

      // Read data is only present this cycle; park it so the stream can stall.
      CAPTURE: begin
        hold_a_d = qA;
        hold_b_d = qB;
        state_d  = SEND_A;
      end

      SEND_A: begin
        out_valid = 1'b1;
        out_data  = hold_a_q;
        if (out_ready) begin
          csum_d  = csum_q + hold_a_q;
          state_d = SEND_B;
        end
      end

      SEND_B: begin
        out_valid = 1'b1;
        out_data  = hold_b_q;
        out_last  = is_last;
        if (out_ready) begin
          csum_d = csum_q + hold_b_q;
          if (is_last) begin
            // Compare against the post-transfer sum so sum_match is
            // already valid while done is high.
            match_d = (csum_d == exp_q);
            state_d = DONE;
          end else begin
            pair_d  = pair_q + PW'(1);
            state_d = FETCH;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        match_d = (csum_q == exp_q);
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_result_reader.sv
// Directed bench for result_reader: RAM model, scoreboard of expected
// elements, stall-stability monitor, latency and checksum checks.
module tb_result_reader;

  localparam int AW = 7;
  localparam int RW = 24;
  localparam int N  = 128;

  typedef struct packed {
    logic [RW-1:0] data;
    logic          last;
  } exp_t;

  logic          clock;
  logic          reset;
  logic          start;
  logic [RW-1:0] expected_sum;
  logic [AW-1:0] addrA;
  logic [AW-1:0] addrB;
  logic [RW-1:0] qA;
  logic [RW-1:0] qB;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [RW-1:0] checksum;
  logic          sum_match;

  int total = 0;
  int bad   = 0;
  int xfer_cnt = 0;
  bit ready_toggle = 0;

  exp_t          sb_q[$];
  logic [RW-1:0] mem [0:N-1];

  result_reader #(.ADDR_WIDTH(AW), .RESULT_WIDTH(RW)) dut (
    .clock(clock), .reset(reset), .start(start), .expected_sum(expected_sum),
    .addrA(addrA), .addrB(addrB), .qA(qA), .qB(qB),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done),
    .checksum(checksum), .sum_match(sum_match)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read dual-port RAM model.
  always @(posedge clock) begin
    qA <= mem[addrA];
    qB <= mem[addrB];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sink ready: tied high or the repeating 1,0,0,1 pattern.
  initial begin
    bit [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (ready_toggle) begin
        out_ready = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        out_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // Stream monitor: scoreboard compare on transfers, stability during stalls.
  initial begin
    logic [RW-1:0] st_data;
    logic          st_last;
    bit            stalled;
    exp_t          e;
    stalled = 0;
    forever begin
      @(negedge clock);
      if (!reset && out_valid) begin
        if (stalled) begin
          chk("stall_data", out_data, st_data);
          chk("stall_last", out_last, st_last);
        end
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            chk("sb_extra_element", sb_q.size(), 1);
          end else begin
            e = sb_q.pop_front();
            chk("stream_data", out_data, e.data);
            chk("stream_last", out_last, e.last);
          end
          xfer_cnt++;
          stalled = 0;
        end else begin
          stalled = 1;
          st_data = out_data;
          st_last = out_last;
        end
      end else begin
        if (stalled && !reset) chk("valid_dropped", out_valid, 1);
        stalled = 0;
      end
    end
  end

  // mode 0: identity, 1: all ones, 2: identity with RAM[5] corrupted to 9.
  task automatic load(input int mode);
    exp_t e;
    sb_q.delete();
    for (int i = 0; i < N; i++) begin
      case (mode)
        1:       mem[i] = 24'hFFFFFF;
        2:       mem[i] = (i == 5) ? 24'd9 : RW'(i);
        default: mem[i] = RW'(i);
      endcase
      e.data = mem[i];
      e.last = (i == N - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic drain(input logic [RW-1:0] esum, input logic [RW-1:0] exp_ck,
                       input logic exp_match, input bit chk_lat, input bit poke);
    int cyc;
    bit timed_out;
    xfer_cnt = 0;
    timed_out = 0;
    @(negedge clock);
    expected_sum = esum;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 1;
    chk("busy_after_start", busy, 1);
    forever begin
      @(negedge clock);
      if (done === 1'b1) break;
      if (cyc > 3000) begin
        timed_out = 1;
        break;
      end
      if (poke && cyc == 60) start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      cyc++;
    end
    if (timed_out) begin
      chk("done_timeout", done, 1);
    end else begin
      if (chk_lat) chk("done_latency", cyc, 257);
      chk("final_checksum", checksum, exp_ck);
      chk("sum_match_at_done", sum_match, exp_match);
      chk("xfer_count", xfer_cnt, N);
      chk("sb_drained", sb_q.size(), 0);
      if (poke) start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      @(negedge clock);
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
      chk("sum_match_held", sum_match, exp_match);
      chk("checksum_held", checksum, exp_ck);
      repeat (5) @(negedge clock);
      chk("still_idle", busy, 0);
      chk("no_extra_xfers", xfer_cnt, N);
    end
  endtask

  initial begin
    int cyc;
    fork
      begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
      end
    join_none

    reset = 1'b1;
    start = 1'b0;
    expected_sum = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (3) @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_sum_match", sum_match, 0);
    chk("rst_addrA", addrA, 0);
    chk("rst_addrB", addrB, 1);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // 1: identity data, ready tied high, latency check.
    load(0);
    drain(24'd8128, 24'd8128, 1'b1, 1'b1, 1'b0);

    // 2: same data with 1,0,0,1 backpressure.
    ready_toggle = 1;
    load(0);
    drain(24'd8128, 24'd8128, 1'b1, 1'b0, 1'b0);
    ready_toggle = 0;
    repeat (2) @(negedge clock);

    // 3: all ones, sum wraps.
    load(1);
    drain(24'hFFFF80, 24'hFFFF80, 1'b1, 1'b1, 1'b0);

    // 4: one corrupted element.
    load(2);
    drain(24'd8128, 24'd8132, 1'b0, 1'b1, 1'b0);

    // 5: reset during SEND_B of pair 10, then a full clean drain.
    load(0);
    @(negedge clock);
    expected_sum = 24'd8128;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    cyc = 0;
    forever begin
      @(posedge clock);
      #2;
      cyc++;
      if (out_valid && addrB == 7'd21 && out_data == 24'd21) break;
      if (cyc > 2000) break;
    end
    chk("reached_pair10_sendb", out_data, 21);
    reset = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_checksum", checksum, 0);
    chk("abort_done", done, 0);
    chk("abort_addrA", addrA, 0);
    sb_q.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("abort_no_done", done, 0);
    load(0);
    drain(24'd8128, 24'd8128, 1'b1, 1'b1, 1'b0);

    // 6: start pulses while busy and on the done cycle are ignored.
    load(0);
    drain(24'd8128, 24'd8128, 1'b1, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
